// File: rtl/ddr3_pkg.sv
// ddr3_pkg: command encodings and burst constants shared by the DDR3 responder
package ddr3_pkg;
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;
  localparam int BL = 8;
  localparam int A10 = 10;
  localparam int MAPW = 24;
endpackage

// File: rtl/ddr3_cmd_responder_if.sv
// ddr3_cmd_responder_if: DDR3 pin bundle between a controller and the responder
interface ddr3_cmd_responder_if #(
  parameter int ADDRESS_BITWIDTH = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH = 16
);
  logic ck_en;
  logic cs_n;
  logic ras_n;
  logic cas_n;
  logic we_n;
  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address;
  logic [ADDRESS_BITWIDTH-1:0] address;
  logic [DQ_BITWIDTH-1:0] dq_in;
  logic ldm;
  logic udm;
  logic [DQ_BITWIDTH-1:0] dq_out;
  logic dq_oe;
  logic [2**BANK_ADDRESS_BITWIDTH-1:0] open_banks;
  logic err;
  modport master (
    output ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dq_in, ldm, udm,
    input  dq_out, dq_oe, open_banks, err
  );
  modport slave (
    input  ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dq_in, ldm, udm,
    output dq_out, dq_oe, open_banks, err
  );
endinterface

// File: rtl/ddr3_burst_slot.sv
// ddr3_burst_slot: latency delay line feeding a BL8 beat counter, with spacing and data-window tracking
module ddr3_burst_slot
  import ddr3_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int W = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic [W-1:0] tag,
  output logic ready,
  output logic [MAPW-1:0] busy,
  output logic active,
  output logic [2:0] beat,
  output logic [W-1:0] cur
);
  localparam int D = LATENCY > 1 ? LATENCY - 1 : 1;
  localparam int TW = D * W;
  localparam logic [MAPW-1:0] WIN = MAPW'((1 << BL) - 1) << (LATENCY - 1);
  logic [D-1:0] pend;
  logic [D-1:0][W-1:0] pend_tag;
  logic [2:0] gap;
  logic go;
  logic [W-1:0] go_tag;
  assign go = LATENCY == 1 ? start : pend[D-1];
  assign go_tag = LATENCY == 1 ? tag : pend_tag[D-1];
  assign ready = gap == 3'd0;
  // walk accepted commands toward burst start; track min spacing and the future data window
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend <= '0;
      gap <= '0;
      busy <= '0;
    end else begin
      pend <= D'({pend, start});
      gap <= start ? 3'(BL - 1) : gap - 3'(gap != 3'd0);
      busy <= (busy >> 1) | (start ? WIN : '0);
    end
  end
  // carry each command's storage index alongside its start pulse
  always_ff @(posedge clk) pend_tag <= TW'({pend_tag, tag});
  // beat counter; a due burst restarts it so consecutive bursts run seamlessly
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active <= 1'b0;
      beat <= '0;
    end else if (go) begin
      active <= 1'b1;
      beat <= '0;
      cur <= go_tag;
    end else if (active) begin
      active <= beat != 3'(BL - 1);
      beat <= beat + 3'd1;
    end
  end
endmodule

// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 decoder with bank tracking, burst storage and fixed-latency reads
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH = 16,
  parameter int CL = 5,
  parameter int CWL = 5,
  parameter int ROW_LSBS = 2,
  parameter int COL_LSBS = 5
) (
  input logic clk,
  input logic resetn,
  input logic reset_n,
  ddr3_cmd_responder_if.slave bus
);
  localparam int NB = 2 ** BANK_ADDRESS_BITWIDTH;
  localparam int IW = BANK_ADDRESS_BITWIDTH + ROW_LSBS + COL_LSBS;
  localparam int H = DQ_BITWIDTH / 2;
  localparam logic [MAPW-1:0] RD_WIN = MAPW'((1 << BL) - 1) << CL;
  localparam logic [MAPW-1:0] WR_WIN = MAPW'((1 << BL) - 1) << CWL;
  logic rst_n, valid, bank_open, ap, bad;
  logic is_act, is_pre, is_rd, is_wr, rd_go, wr_go;
  cmd_e cmd;
  logic [NB-1:0] open;
  logic err;
  logic [ROW_LSBS-1:0] row [NB];
  logic [DQ_BITWIDTH-1:0] mem [2**IW];
  logic [IW-1:0] tag, rd_tag, wr_tag, rd_idx, wr_idx;
  logic rd_ready, wr_ready, rd_active, wr_active;
  logic [MAPW-1:0] rd_busy, wr_busy;
  logic [2:0] rd_beat, wr_beat;
  assign rst_n = resetn & reset_n;
  assign valid = bus.ck_en & ~bus.cs_n;
  assign cmd = cmd_e'({bus.ras_n, bus.cas_n, bus.we_n});
  assign ap = bus.address[A10];
  assign bank_open = open[bus.bank_address];
  assign tag = {bus.bank_address, row[bus.bank_address], bus.address[COL_LSBS-1:0]};
  // classify the command; bursts need an open bank, legal spacing and no clash with the other direction
  always_comb begin
    is_act = valid && cmd == CMD_ACT;
    is_pre = valid && cmd == CMD_PRE;
    is_rd = valid && cmd == CMD_RD;
    is_wr = valid && cmd == CMD_WR;
    rd_go = is_rd && bank_open && rd_ready && !(|(wr_busy & RD_WIN));
    wr_go = is_wr && bank_open && wr_ready && !(|(rd_busy & WR_WIN));
    bad = (is_act && bank_open) || (is_rd && !rd_go) || (is_wr && !wr_go);
  end
  // open-bank flags and the sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open <= '0;
      err <= 1'b0;
    end else begin
      if (is_act) open[bus.bank_address] <= 1'b1;
      if (is_pre) open <= ap ? '0 : open & ~(NB'(1) << bus.bank_address);
      if ((rd_go || wr_go) && ap) open[bus.bank_address] <= 1'b0;
      err <= err | bad;
    end
  end
  // row bits that select storage, captured on activate
  always_ff @(posedge clk) if (rst_n && is_act) row[bus.bank_address] <= bus.address[ROW_LSBS-1:0];
  // byte-masked write of the current write beat; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_active && !bus.ldm) mem[wr_idx][H-1:0] <= bus.dq_in[H-1:0];
    if (rst_n && wr_active && !bus.udm) mem[wr_idx][DQ_BITWIDTH-1:H] <= bus.dq_in[DQ_BITWIDTH-1:H];
  end
  assign rd_idx = {rd_tag[IW-1:3], rd_tag[2:0] + rd_beat};
  assign wr_idx = {wr_tag[IW-1:3], wr_tag[2:0] + wr_beat};
  assign bus.dq_out = rd_active ? mem[rd_idx] : '0;
  assign bus.dq_oe = rd_active;
  assign bus.open_banks = open;
  assign bus.err = err;
  ddr3_burst_slot #(.LATENCY(CL), .W(IW)) u_rd (
    .clk(clk), .resetn(rst_n), .start(rd_go), .tag(tag), .ready(rd_ready),
    .busy(rd_busy), .active(rd_active), .beat(rd_beat), .cur(rd_tag)
  );
  ddr3_burst_slot #(.LATENCY(CWL), .W(IW)) u_wr (
    .clk(clk), .resetn(rst_n), .start(wr_go), .tag(tag), .ready(wr_ready),
    .busy(wr_busy), .active(wr_active), .beat(wr_beat), .cur(wr_tag)
  );
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// tb_ddr3_cmd_responder: scoreboard bench for the DDR3 responder
module tb_ddr3_cmd_responder;
  import ddr3_pkg::*;
  localparam int CL = 5;
  localparam int CWL = 5;
  typedef struct {
    int cyc;
    logic [15:0] data;
  } beat_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic reset_n = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  beat_t q[$];
  beat_t e;
  logic [15:0] mdl [1024];
  int mrow [8];

  ddr3_cmd_responder_if bus ();
  ddr3_cmd_responder #(.CL(CL), .CWL(CWL)) dut (
    .clk(clk), .resetn(resetn), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // read-beat monitor: each driven beat must match the oldest expected beat in time and value
  always @(negedge clk) begin
    if (bus.dq_oe === 1'b1) begin
      if (q.size() == 0) chk("oe_unexpected", {31'd0, bus.dq_oe}, 32'd0);
      else begin
        e = q.pop_front();
        chk("beat_cycle", cyc, e.cyc);
        chk("beat_data", {16'd0, bus.dq_out}, {16'd0, e.data});
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      chk("beat_missing", {31'd0, bus.dq_oe}, 32'd1);
      void'(q.pop_front());
    end
  end

  function automatic int idx(int b, int c, int k);
    return b * 128 + (mrow[b] & 3) * 32 + (c & 24) + ((c + k) & 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(cmd_e c, int b, int a);
    bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.bank_address = 3'(b);
    bus.address = 15'(a);
    tick();
    bus.cs_n = 1'b1;
    {bus.ras_n, bus.cas_n, bus.we_n} = CMD_NOP;
  endtask

  task automatic act(int b, int r);
    mrow[b] = r;
    cmd(CMD_ACT, b, r);
  endtask

  task automatic wr(int b, int c, logic [15:0] d0, bit inc, int mask_beat);
    int i;
    cmd(CMD_WR, b, c);
    repeat (CWL - 1) tick();
    for (int k = 0; k < 8; k++) begin
      bus.dq_in = inc ? 16'(d0 + 16'(k)) : d0;
      bus.ldm = (k == mask_beat);
      bus.udm = 1'b0;
      i = idx(b, c, k);
      if (!bus.ldm) mdl[i][7:0] = bus.dq_in[7:0];
      mdl[i][15:8] = bus.dq_in[15:8];
      tick();
    end
    bus.ldm = 1'b0;
  endtask

  task automatic rd(int b, int c, bit a10, bit ok);
    int c0 = cyc;
    if (ok) for (int k = 0; k < 8; k++) q.push_back('{c0 + CL + k, mdl[idx(b, c, k)]});
    cmd(CMD_RD, b, c | (int'(a10) << A10));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.ck_en = 1'b1;
    bus.cs_n = 1'b1;
    {bus.ras_n, bus.cas_n, bus.we_n} = CMD_NOP;
    bus.bank_address = '0;
    bus.address = '0;
    bus.dq_in = '0;
    bus.ldm = 1'b0;
    bus.udm = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("rst_oe", {31'd0, bus.dq_oe}, 0);
    chk("rst_dq", {16'd0, bus.dq_out}, 0);
    chk("rst_open", {24'd0, bus.open_banks}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);

    act(2, 1);
    chk("act_open", {24'd0, bus.open_banks}, 32'h04);
    wr(2, 0, 16'h1000, 1'b1, -1);
    rd(2, 0, 1'b0, 1'b1);
    drain();
    chk("basic_err", {31'd0, bus.err}, 0);
    rd(2, 5, 1'b0, 1'b1);
    drain();
    wr(2, 0, 16'hFFFF, 1'b0, 2);
    rd(2, 0, 1'b0, 1'b1);
    drain();
    chk("mask_err", {31'd0, bus.err}, 0);
    rd(2, 0, 1'b0, 1'b1);
    repeat (7) tick();
    rd(2, 0, 1'b0, 1'b1);
    drain();
    chk("b2b_err", {31'd0, bus.err}, 0);

    do_reset();
    rd(5, 0, 1'b0, 1'b0);
    repeat (12) tick();
    chk("closed_err", {31'd0, bus.err}, 1);
    do_reset();
    chk("err_cleared", {31'd0, bus.err}, 0);
    act(2, 1);
    act(2, 1);
    chk("act_open_err", {31'd0, bus.err}, 1);
    do_reset();
    act(2, 1);
    rd(2, 0, 1'b0, 1'b1);
    repeat (3) tick();
    rd(2, 0, 1'b0, 1'b0);
    drain();
    chk("spacing_err", {31'd0, bus.err}, 1);
    do_reset();
    act(2, 1);
    bus.ldm = 1'b1;
    bus.udm = 1'b1;
    cmd(CMD_WR, 2, 0);
    rd(2, 0, 1'b0, 1'b0);
    repeat (14) tick();
    bus.ldm = 1'b0;
    bus.udm = 1'b0;
    chk("overlap_err", {31'd0, bus.err}, 1);

    do_reset();
    for (int b = 0; b < 8; b++) act(b, 1);
    chk("all_open", {24'd0, bus.open_banks}, 32'hFF);
    cmd(CMD_PRE, 4, 0);
    chk("pre_one", {24'd0, bus.open_banks}, 32'hEF);
    cmd(CMD_PRE, 0, 1 << A10);
    chk("pre_all", {24'd0, bus.open_banks}, 0);
    act(3, 1);
    wr(3, 0, 16'h3000, 1'b1, -1);
    rd(3, 0, 1'b1, 1'b1);
    chk("auto_pre", {24'd0, bus.open_banks}, 0);
    drain();
    chk("ap_err", {31'd0, bus.err}, 0);
    rd(3, 0, 1'b0, 1'b0);
    repeat (12) tick();
    chk("ap_closed_err", {31'd0, bus.err}, 1);

    for (int p = 0; p < 2; p++) begin
      do_reset();
      act(2, 1);
      rd(2, 0, 1'b0, 1'b1);
      repeat (7) tick();
      if (p == 1) reset_n = 1'b0;
      else resetn = 1'b0;
      tick();
      q.delete();
      chk("mid_rst_oe", {31'd0, bus.dq_oe}, 0);
      chk("mid_rst_open", {24'd0, bus.open_banks}, 0);
      chk("mid_rst_dq", {16'd0, bus.dq_out}, 0);
      resetn = 1'b1;
      reset_n = 1'b1;
      tick();
      act(2, 1);
      rd(2, 0, 1'b0, 1'b1);
      drain();
      chk("post_rst_err", {31'd0, bus.err}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
